// File: rtl/sram_pkg.sv
// Shared constants and state type for the SRAM readout path.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W    = 20;
    localparam int unsigned SRAM_DATA_W    = 16;
    localparam int unsigned WORDS_PER_SCAN = 52;

    // Largest word count a readout can address without wrapping the address counter.
    localparam logic [31:0] MAX_WORDS = 32'((1 << SRAM_ADDR_W) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFinish
    } readout_state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data_o shows the head word while not empty.
module word_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 16,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [PtrW-1:0] PtrOne  = 1;
    localparam logic [CntW-1:0] CntOne  = 1;
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             wr, rd;

    assign full_o    = (count_q == CntFull);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr        = wr_en_i && !full_o;
    assign rd        = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
        end
        if (rd) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
        end
        unique case ({wr, rd})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sram_readout.sv
// Reads a captured ping out of SRAM (addresses 1..total) and streams it as bytes,
// low byte of each word first, with flow control against a small word buffer.
module sram_readout
    import sram_pkg::*;
#(
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned WORDS_PER_SCAN = sram_pkg::WORDS_PER_SCAN,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [31:0]            num_scans,
    input  logic                   sram_packet_formed_i,
    input  logic [SRAM_DATA_W-1:0] sram_q,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_ld_addr_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int unsigned            CntW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [SRAM_ADDR_W-1:0] AddrOne = 1;
    localparam logic [SRAM_ADDR_W:0]   ByteOne = 1;

    readout_state_e         state_q, state_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d, issued_q, issued_d, total_q, total_d;
    logic [SRAM_ADDR_W:0]   bytes_q, bytes_d;
    logic                   err_q, err_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [7:0]             hi_byte_q, hi_byte_d, tx_data_q, tx_data_d;
    logic                   hi_q, hi_d, tx_valid_q, tx_valid_d;

    logic                   issue, fifo_rd, fifo_full, fifo_empty, tx_fire, last_byte;
    logic [SRAM_DATA_W-1:0] fifo_rdata;
    logic [CntW-1:0]        fifo_count;
    logic [31:0]            total_full;
    int unsigned            in_flight;

    word_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (SRAM_DATA_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (pipe_q[READ_LATENCY-1]),
        .wr_data_i (sram_q),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Buffered plus in-flight words must stay below depth so every returning read has a slot.
    always_comb begin
        in_flight = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight += 32'(pipe_q[i]);
        end
        issue = (state_q == StIssue) && !fifo_full &&
                ((32'(fifo_count) + in_flight) < FIFO_DEPTH);
        pipe_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign tx_fire    = tx_valid_q && tx_ready_i;
    assign last_byte  = tx_fire && (bytes_q == ({total_q, 1'b0} - ByteOne));
    assign total_full = num_scans * 32'(WORDS_PER_SCAN);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        total_d  = total_q;
        bytes_d  = tx_fire ? bytes_q + ByteOne : bytes_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && sram_packet_formed_i) begin
                    addr_d   = AddrOne;
                    issued_d = '0;
                    bytes_d  = '0;
                    err_d    = 1'b0;
                    total_d  = total_full[SRAM_ADDR_W-1:0];
                    // A zero product also covers a 32-bit wrap to zero.
                    if (total_full == '0) begin
                        state_d = StFinish;
                    end else if (total_full > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (issue) begin
                    addr_d   = addr_q + AddrOne;
                    issued_d = issued_q + AddrOne;
                    if (issued_d == total_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last_byte) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        hi_byte_d  = hi_byte_q;
        hi_d       = hi_q;
        fifo_rd    = 1'b0;
        if (!tx_valid_q || tx_ready_i) begin
            if (tx_valid_q && !hi_q) begin
                tx_data_d = hi_byte_q;
                hi_d      = 1'b1;
            end else if (!fifo_empty) begin
                fifo_rd    = 1'b1;
                tx_data_d  = fifo_rdata[7:0];
                hi_byte_d  = fifo_rdata[15:8];
                hi_d       = 1'b0;
                tx_valid_d = 1'b1;
            end else begin
                tx_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            issued_q   <= '0;
            total_q    <= '0;
            bytes_q    <= '0;
            err_q      <= 1'b0;
            pipe_q     <= '0;
            hi_byte_q  <= '0;
            tx_data_q  <= '0;
            hi_q       <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            total_q    <= total_d;
            bytes_q    <= bytes_d;
            err_q      <= err_d;
            pipe_q     <= pipe_d;
            hi_byte_q  <= hi_byte_d;
            tx_data_q  <= tx_data_d;
            hi_q       <= hi_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign sram_addr      = addr_q;
    assign sram_ld_addr_n = !issue;
    assign sram_oe_n      = !((state_q == StIssue) || (|pipe_q));
    assign sram_we_n      = 1'b1;
    assign tx_data_o      = tx_data_q;
    assign tx_valid_o     = tx_valid_q;
    assign busy_o         = (state_q == StIssue) || (state_q == StDrain);
    assign done_o         = (state_q == StFinish);
    assign err_o          = err_q;

endmodule
